// File: rtl/perf_monitor_unit.sv
// Performance monitor: programmable event counters, a saturating cycle counter
// with watchdog, halt freeze, and a registered one-cycle readout port.
module perf_monitor_unit #(
  parameter int NUM_CNT = 4,
  parameter int CNT_W   = 32,
  parameter int NUM_EVT = 8,
  parameter int TIMEOUT = 100000,
  localparam int IDX_W  = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1,
  localparam int SEL_W  = $clog2(NUM_EVT + 1),
  localparam int RD_W   = $clog2(NUM_CNT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               start,
  input  logic               halt,
  input  logic               clear,
  input  logic               cfg_wen,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [SEL_W-1:0]   cfg_sel,
  input  logic               cfg_sat,
  input  logic               rd_en,
  input  logic [RD_W-1:0]    rd_idx,
  output logic [CNT_W-1:0]   rd_data,
  output logic               rd_valid,
  output logic [NUM_CNT-1:0] ovf,
  output logic               timeout,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_FROZEN = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d [NUM_CNT];
  logic [SEL_W-1:0]   sel_q [NUM_CNT];
  logic [SEL_W-1:0]   sel_d [NUM_CNT];
  logic [NUM_CNT-1:0] sat_q, sat_d;
  logic [NUM_CNT-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   rd_data_q;
  logic               rd_valid_q;

  logic [NUM_EVT:0]   evt_ext;
  logic [NUM_CNT-1:0] hit;
  logic               wd_hit;
  logic [CNT_W-1:0]   rd_mux;

  // The extra top bit stands for the "every cycle" select value.
  assign evt_ext = {1'b1, evt};

  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      for (int e = 0; e <= NUM_EVT; e++) begin
        if (sel_q[k] == SEL_W'(e)) hit[k] = evt_ext[e];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    sat_d     = sat_q;
    ovf_d     = ovf_q;
    cyc_d     = cyc_q;
    timeout_d = timeout_q;
    wd_hit    = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      for (int k = 0; k < NUM_CNT; k++) cnt_d[k] = '0;
      ovf_d     = '0;
      cyc_d     = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (halt)       state_d = S_FROZEN;
          else if (start) state_d = S_RUN;
        end
        S_RUN: begin
          for (int k = 0; k < NUM_CNT; k++) begin
            if (hit[k]) begin
              if (cnt_q[k] == '1) begin
                ovf_d[k] = 1'b1;
                if (!sat_q[k]) cnt_d[k] = '0;
              end else begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
              end
            end
          end
          if (cyc_q != '1) cyc_d = cyc_q + CNT_W'(1);
          // Compare wide so a TIMEOUT beyond the counter range simply never fires.
          wd_hit = (TIMEOUT != 0) && (64'(cyc_d) == 64'(TIMEOUT));
          if (wd_hit) timeout_d = 1'b1;
          if (halt || wd_hit) state_d = S_FROZEN;
        end
        S_FROZEN: state_d = S_FROZEN;
        default:  state_d = S_IDLE;
      endcase
      // A configuration write overrides any count made by that counter this cycle.
      if (cfg_wen) begin
        for (int k = 0; k < NUM_CNT; k++) begin
          if (cfg_idx == IDX_W'(k)) begin
            sel_d[k] = cfg_sel;
            sat_d[k] = cfg_sat;
            cnt_d[k] = '0;
            ovf_d[k] = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (rd_idx == RD_W'(k)) rd_mux = cnt_q[k];
    end
    if (rd_idx == RD_W'(NUM_CNT)) rd_mux = cyc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int k = 0; k < NUM_CNT; k++) begin
        cnt_q[k] <= '0;
        sel_q[k] <= '0;
      end
      sat_q      <= '0;
      ovf_q      <= '0;
      cyc_q      <= '0;
      timeout_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int k = 0; k < NUM_CNT; k++) begin
        cnt_q[k] <= cnt_d[k];
        sel_q[k] <= sel_d[k];
      end
      sat_q      <= sat_d;
      ovf_q      <= ovf_d;
      cyc_q      <= cyc_d;
      timeout_q  <= timeout_d;
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_mux;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign ovf      = ovf_q;
  assign timeout  = timeout_q;
  assign state    = state_q;

endmodule

// File: tb/tb_perf_monitor_unit.sv
// Bench for perf_monitor_unit: a narrow-counter instance (no watchdog) checked
// against a behavioural model every cycle, plus a watchdog instance.
module tb_perf_monitor_unit;

  localparam int NC    = 4;
  localparam int NE    = 8;
  localparam int A_MAX = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] evt;
  logic       start, halt, clear, cfg_wen, cfg_sat, rd_en;
  logic [1:0] cfg_idx;
  logic [3:0] cfg_sel;
  logic [2:0] rd_idx;

  logic [3:0]  rd_data_a, ovf_a;
  logic        rd_valid_a, timeout_a;
  logic [1:0]  state_a;
  logic [15:0] rd_data_b;
  logic [3:0]  ovf_b;
  logic        rd_valid_b, timeout_b;
  logic [1:0]  state_b;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  perf_monitor_unit #(.NUM_CNT(NC), .CNT_W(4), .NUM_EVT(NE), .TIMEOUT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .evt(evt), .start(start), .halt(halt), .clear(clear),
    .cfg_wen(cfg_wen), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_sat(cfg_sat),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .ovf(ovf_a), .timeout(timeout_a), .state(state_a)
  );

  perf_monitor_unit #(.NUM_CNT(NC), .CNT_W(16), .NUM_EVT(NE), .TIMEOUT(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .evt(evt), .start(start), .halt(halt), .clear(clear),
    .cfg_wen(cfg_wen), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_sat(cfg_sat),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .ovf(ovf_b), .timeout(timeout_b), .state(state_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of dut_a: states 0 idle, 1 run, 2 frozen.
  int       m_cnt [NC];
  int       m_sel [NC];
  bit       m_sat [NC];
  logic [3:0] m_ovf = '0;
  int       m_cyc = 0;
  int       m_state = 0;
  bit       m_rdv = 0;
  int       m_rdd = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NC; k++) begin
        m_cnt[k] = 0; m_sel[k] = 0; m_sat[k] = 0;
      end
      m_ovf = '0; m_cyc = 0; m_state = 0; m_rdv = 0; m_rdd = 0;
    end else begin
      m_rdv = rd_en;
      if (rd_en) m_rdd = (rd_idx < NC) ? m_cnt[rd_idx] : ((rd_idx == NC) ? m_cyc : 0);
      if (clear) begin
        for (int k = 0; k < NC; k++) m_cnt[k] = 0;
        m_ovf = '0; m_cyc = 0; m_state = 0;
      end else begin
        if (m_state == 1) begin
          for (int k = 0; k < NC; k++) begin
            if (m_sel[k] == NE || (m_sel[k] < NE && evt[m_sel[k]])) begin
              int v;
              v = m_cnt[k] + 1;
              if (v > A_MAX) begin
                m_ovf[k] = 1'b1;
                v = m_sat[k] ? A_MAX : v % (A_MAX + 1);
              end
              m_cnt[k] = v;
            end
          end
          m_cyc = (m_cyc + 1 > A_MAX) ? A_MAX : m_cyc + 1;
          if (halt) m_state = 2;
        end else if (m_state == 0) begin
          if (halt) m_state = 2;
          else if (start) m_state = 1;
        end
        if (cfg_wen) begin
          m_sel[cfg_idx] = cfg_sel;
          m_sat[cfg_idx] = cfg_sat;
          m_cnt[cfg_idx] = 0;
          m_ovf[cfg_idx] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("mdl_state", state_a, m_state);
      chk("mdl_rd_valid", rd_valid_a, m_rdv);
      chk("mdl_ovf", ovf_a, m_ovf);
      chk("mdl_timeout", timeout_a, 0);
      if (m_rdv) chk("mdl_rd_data", rd_data_a, m_rdd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    evt = '0; start = 0; halt = 0; clear = 0; cfg_wen = 0; rd_en = 0;
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [3:0] sel, input logic sat);
    cfg_wen = 1; cfg_idx = idx; cfg_sel = sel; cfg_sat = sat;
    tick();
    cfg_wen = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    tick();
    clear = 0;
  endtask

  task automatic read_chk(input string nm, input logic [2:0] idx, input logic [3:0] exp);
    rd_en = 1; rd_idx = idx;
    tick();
    chk({nm, "_valid"}, rd_valid_a, 1);
    chk(nm, rd_data_a, exp);
    rd_en = 0;
  endtask

  task automatic wrap_run(input logic sat, input logic [3:0] e_cnt);
    idle_in();
    do_clear();
    cfg(2'd1, 4'd8, sat);
    start = 1; tick(); start = 0;
    for (int i = 0; i < 17; i++) begin
      halt = (i == 16);
      tick();
    end
    halt = 0;
    chk("ovf_state", state_a, 2);
    chk("ovf_flags", ovf_a, 4'b0010);
    read_chk("ovf_cnt1", 3'd1, e_cnt);
    read_chk("ovf_cyc_sat", 3'd4, 4'd15);
  endtask

  typedef struct {
    logic [7:0] evt;
    logic       start, halt, clear, rd_en;
    logic [2:0] rd_idx;
    logic [1:0] e_state;
    logic       e_rv;
    logic [3:0] e_rd;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic [7:0] e, input logic s, input logic h, input logic c,
                              input logic r, input logic [2:0] ri, input logic [1:0] es,
                              input logic erv, input logic [3:0] erd);
    vec_t v;
    v.evt = e; v.start = s; v.halt = h; v.clear = c; v.rd_en = r; v.rd_idx = ri;
    v.e_state = es; v.e_rv = erv; v.e_rd = erd;
    return v;
  endfunction

  initial begin
    int n;
    idle_in();
    cfg_idx = '0; cfg_sel = '0; cfg_sat = 0; rd_idx = '0;

    // All counters select evt[0] out of reset.
    tbl[0]  = mk(8'h00, 1, 0, 0, 0, 3'd0, 2'd1, 0, 4'd0);
    tbl[1]  = mk(8'h01, 0, 0, 0, 0, 3'd0, 2'd1, 0, 4'd0);
    tbl[2]  = mk(8'h01, 0, 0, 0, 0, 3'd0, 2'd1, 0, 4'd0);
    tbl[3]  = mk(8'h01, 0, 0, 0, 1, 3'd0, 2'd1, 1, 4'd2);
    tbl[4]  = mk(8'h01, 0, 0, 0, 1, 3'd4, 2'd1, 1, 4'd3);
    tbl[5]  = mk(8'h01, 0, 0, 0, 1, 3'd1, 2'd1, 1, 4'd4);
    tbl[6]  = mk(8'h00, 0, 1, 0, 0, 3'd0, 2'd2, 0, 4'd0);
    tbl[7]  = mk(8'h00, 0, 0, 0, 1, 3'd0, 2'd2, 1, 4'd5);
    tbl[8]  = mk(8'h01, 1, 0, 0, 0, 3'd0, 2'd2, 0, 4'd0);
    tbl[9]  = mk(8'h00, 0, 0, 0, 1, 3'd0, 2'd2, 1, 4'd5);
    tbl[10] = mk(8'h00, 0, 0, 1, 0, 3'd0, 2'd0, 0, 4'd0);
    tbl[11] = mk(8'h00, 0, 0, 0, 1, 3'd0, 2'd0, 1, 4'd0);
    tbl[12] = mk(8'h00, 1, 0, 0, 0, 3'd0, 2'd1, 0, 4'd0);
    tbl[13] = mk(8'h01, 0, 1, 0, 0, 3'd0, 2'd2, 0, 4'd0);
    tbl[14] = mk(8'h01, 0, 0, 0, 0, 3'd0, 2'd2, 0, 4'd0);
    tbl[15] = mk(8'h00, 0, 0, 0, 1, 3'd0, 2'd2, 1, 4'd1);
    tbl[16] = mk(8'h00, 0, 0, 1, 0, 3'd0, 2'd0, 0, 4'd0);
    tbl[17] = mk(8'h00, 0, 1, 0, 0, 3'd0, 2'd2, 0, 4'd0);
    tbl[18] = mk(8'h00, 0, 0, 0, 1, 3'd4, 2'd2, 1, 4'd0);
    tbl[19] = mk(8'h00, 0, 0, 0, 1, 3'd5, 2'd2, 1, 4'd0);
    tbl[20] = mk(8'h00, 0, 0, 1, 1, 3'd7, 2'd0, 1, 4'd0);

    tick(); tick();
    chk("rst_state", state_a, 0);
    chk("rst_rd_valid", rd_valid_a, 0);
    chk("rst_rd_data", rd_data_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_timeout", timeout_a, 0);
    chk("rst_timeout_b", timeout_b, 0);
    rst_n = 1;

    for (int i = 0; i < 21; i++) begin
      evt = tbl[i].evt; start = tbl[i].start; halt = tbl[i].halt; clear = tbl[i].clear;
      rd_en = tbl[i].rd_en; rd_idx = tbl[i].rd_idx;
      tick();
      chk($sformatf("tbl%0d_state", i), state_a, tbl[i].e_state);
      chk($sformatf("tbl%0d_rd_valid", i), rd_valid_a, tbl[i].e_rv);
      if (tbl[i].e_rv) chk($sformatf("tbl%0d_rd_data", i), rd_data_a, tbl[i].e_rd);
    end
    idle_in();
    chk("tbl_ovf", ovf_a, 0);

    wrap_run(1'b0, 4'd1);
    wrap_run(1'b1, 4'd15);

    // Watchdog on the second instance.
    idle_in();
    do_clear();
    start = 1; tick(); start = 0;
    n = 0;
    while (timeout_b == 1'b0 && n < 30) begin
      tick();
      n++;
    end
    chk("wd_cycles", n, 10);
    rd_en = 1; rd_idx = 3'd4;
    tick();
    rd_en = 0;
    chk("wd_state", state_b, 2);
    chk("wd_flag", timeout_b, 1);
    chk("wd_cyc", rd_data_b, 16'd10);

    // Reconfigure counter 2 mid-run while its event is high, then clear mid-run.
    do_clear();
    cfg(2'd2, 4'd3, 1'b0);
    start = 1; tick(); start = 0;
    evt = 8'h08;
    tick(); tick(); tick();
    cfg(2'd2, 4'd3, 1'b0);
    read_chk("cfgw_rd0", 3'd2, 4'd0);
    read_chk("cfgw_rd1", 3'd2, 4'd1);
    do_clear();
    chk("clr_state", state_a, 0);
    chk("clr_ovf", ovf_a, 0);
    read_chk("clr_cnt2", 3'd2, 4'd0);
    start = 1; tick(); start = 0;
    tick(); tick();
    read_chk("cfg_kept", 3'd2, 4'd2);
    idle_in();

    // Back-to-back reads while counting every cycle.
    do_clear();
    cfg(2'd0, 4'd8, 1'b0);
    start = 1; tick(); start = 0;
    rd_en = 1; rd_idx = 3'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold_rd%0d", i), rd_data_a, i);
      chk($sformatf("hold_valid%0d", i), rd_valid_a, 1);
    end
    rd_en = 0;
    tick();
    chk("hold_drop", rd_valid_a, 0);
    read_chk("oor5", 3'd5, 4'd0);
    read_chk("oor6", 3'd6, 4'd0);

    // Random traffic; the model comparisons run every cycle.
    do_clear();
    for (int i = 0; i < 800; i++) begin
      evt     = 8'($urandom);
      start   = ($urandom_range(0, 7) == 0);
      halt    = ($urandom_range(0, 31) == 0);
      clear   = ($urandom_range(0, 39) == 0);
      cfg_wen = ($urandom_range(0, 11) == 0);
      cfg_idx = 2'($urandom_range(0, 3));
      cfg_sel = 4'($urandom_range(0, 15));
      cfg_sat = 1'($urandom_range(0, 1));
      rd_en   = 1'($urandom_range(0, 1));
      rd_idx  = 3'($urandom_range(0, 7));
      tick();
    end
    idle_in();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_monitor_unit.md
Name: perf_monitor_unit

Overview:
Synthesizable hardware performance monitor for the pipelined CPU. It counts retire, I-cache and D-cache request/hit, and stall events in programmable counters. It also runs a free-running cycle counter with a watchdog and freezes all counts when halt is asserted. It sits beside the cpu top level, is fed by pipeline/cache event strobes, and is read out through a registered index/data port.

Parameters:
NUM_CNT, 4, number of programmable event counters
CNT_W, 32, width of each event counter and of the cycle counter
NUM_EVT, 8, width of the event strobe vector
TIMEOUT, 100000, cycle count at which the watchdog flag fires (0 disables it)

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
evt  input  NUM_EVT  per-cycle event strobes (bit i = event i occurred this cycle)
start  input  1  pulse: begin counting
halt  input  1  processor halt; freezes counting
clear  input  1  pulse: zero all counters and flags, return to IDLE
cfg_wen  input  1  write counter configuration
cfg_idx  input  clog2(NUM_CNT)  counter being configured
cfg_sel  input  SEL_W  event select, SEL_W = clog2(NUM_EVT+1); value NUM_EVT = "every cycle"
cfg_sat  input  1  1 = saturate at max, 0 = wrap
rd_en  input  1  readout request
rd_idx  input  clog2(NUM_CNT+1)  counter to read; NUM_CNT = cycle counter
rd_data  output  CNT_W  readout data
rd_valid  output  1  rd_data valid
ovf  output  NUM_CNT  sticky per-counter overflow flags
timeout  output  1  sticky watchdog flag
state  output  2  00 IDLE, 01 RUN, 10 FROZEN

Behaviour:
- Reset: state=IDLE; all counters 0; cfg_sel=0 and cfg_sat=0 for every counter; ovf=0; timeout=0; rd_data=0; rd_valid=0.
- States:
  - IDLE -(start)-> RUN.
  - RUN -(halt)-> FROZEN.
  - RUN -(timeout reached)-> FROZEN.
  - Any state -(clear)-> IDLE.
  - FROZEN ignores start until clear.
- Priority within a cycle: rst_n > clear > cfg_wen > counting.
- Counting occurs only in RUN, including the cycle in which halt is sampled.
  - Events coincident with halt are counted, and the transition to FROZEN takes effect next cycle.
  - halt in IDLE: go to FROZEN directly, counting nothing.
- Counter k increments by 1 when (cfg_sel[k]<NUM_EVT && evt[cfg_sel[k]]) or cfg_sel[k]==NUM_EVT.
  - cfg_sel values above NUM_EVT never count.
- Cycle counter increments every RUN cycle.
- Overflow, applied at increment from all-ones:
  - wrap mode: counter goes to 0 and ovf[k] is set.
  - sat mode: counter holds all-ones and ovf[k] is set.
  - ovf bits clear only on clear or reset.
  - The cycle counter always saturates and has no ovf bit.
- cfg_wen, legal in any state:
  - latches cfg_sel and cfg_sat for counter cfg_idx and zeroes that counter and its ovf bit;
  - that counter does not count in the write cycle;
  - cfg_idx >= NUM_CNT is ignored.
- Watchdog: when the cycle counter reaches TIMEOUT while in RUN, timeout is set in that same cycle and state goes to FROZEN next cycle.
- Readout latency is 1 cycle.
  - rd_en at edge N gives rd_valid=1 and rd_data = counter value as of edge N (pre-update) after edge N.
  - rd_valid deasserts the cycle after rd_en drops.
  - rd_idx > NUM_CNT returns rd_data=0 with rd_valid=1.
  - Reads never disturb counting.
- clear during RUN aborts counting immediately: all counters 0 next cycle, and configuration is retained.
- Counter state persists in FROZEN indefinitely and stays readable.

Test Plan:
- Reset, then start; evt[0] pulsed 5 cycles with cfg_sel[0]=0; then halt -> counter0 reads 5, state=FROZEN, ovf=0.
- evt[1] asserted in the same cycle as halt -> that event is counted; further evt[1] pulses in FROZEN leave the count unchanged.
- CNT_W=4, counter1 wrap, cfg_sel=NUM_EVT, 17 RUN cycles -> counter1=1, ovf[1]=1; same test with cfg_sat=1 -> counter1=15, ovf[1]=1.
- TIMEOUT=10, start, no halt -> timeout=1 when the cycle counter hits 10, state=FROZEN next cycle, rd_idx=NUM_CNT reads 10.
- cfg_wen on counter2 mid-RUN while its event is high -> counter2=0 after the write, then increments from the following cycle; clear mid-RUN -> all counters 0, state=IDLE, config retained.
- rd_en with rd_idx=NUM_CNT+1 -> rd_valid=1, rd_data=0; rd_en held 3 cycles on counter0 while counting -> successive reads show increasing, one-cycle-lagged values.
